// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and framing constants for the serial receiver
package serial_pkg;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam int DEFAULT_DIVISOR = 868;
endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchronizer with a configurable reset level
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic data_in,
   output logic sync_out
);
   logic meta;
   always_ff @(posedge clk_in)
      if (rst_in) {sync_out, meta} <= {RESET_VAL, RESET_VAL};
      else {sync_out, meta} <= {meta, data_in};
endmodule

// File: rtl/serial_rx.sv
// serial_rx: UART-style receiver, 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit
module serial_rx
   import serial_pkg::*;
#(
   parameter int DIVISOR = DEFAULT_DIVISOR,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  data_in,
   output logic [DATA_WIDTH-1:0] val_out,
   output logic                  valid_out,
   output logic                  frame_err_out,
   output logic                  busy_out
);
   localparam int BIT = DIVISOR + 1;
   localparam int HALF = BIT / 2;
   localparam int CW = $clog2(BIT);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(BIT - 1);
   localparam logic [IW-1:0] IND_LAST = IW'(DATA_WIDTH - 1);
   state_t state, state_next;
   logic [CW-1:0] count, count_next;
   logic [IW-1:0] ind, ind_next;
   logic [DATA_WIDTH-1:0] shift, shift_next, val_next;
   logic valid_next, err_next, rx_s, rx_prev, armed;
   logic [1:0] settle;
   bit_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .data_in (data_in),
      .sync_out(rx_s)
   );
   // The synchronizer's reset-forced highs are not real line samples, so edges are
   // only accepted once a genuine high has been seen; a line held low stays quiet.
   always_ff @(posedge clk_in)
      if (rst_in) begin
         state <= S_IDLE;
         count <= '0;
         ind <= '0;
         shift <= '0;
         val_out <= '0;
         valid_out <= 1'b0;
         frame_err_out <= 1'b0;
         busy_out <= 1'b0;
         rx_prev <= 1'b1;
         settle <= '0;
         armed <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         ind <= ind_next;
         shift <= shift_next;
         val_out <= val_next;
         valid_out <= valid_next;
         frame_err_out <= err_next;
         busy_out <= state_next != S_IDLE;
         rx_prev <= rx_s;
         settle <= {settle[0], 1'b1};
         armed <= armed | (settle[1] & rx_s);
      end
   always_comb begin
      state_next = state;
      count_next = count;
      ind_next = ind;
      shift_next = shift;
      val_next = val_out;
      valid_next = 1'b0;
      err_next = 1'b0;
      case (state)
         S_IDLE:
            if (armed && rx_prev && !rx_s) begin
               count_next = '0;
               state_next = S_START;
            end
         S_START:
            if (count == HALF_LAST) begin
               count_next = '0;
               ind_next = '0;
               state_next = (rx_s == START_BIT) ? S_DATA : S_IDLE;
            end else count_next = count + 1'b1;
         S_DATA:
            if (count == BIT_LAST) begin
               count_next = '0;
               shift_next[ind] = rx_s;
               if (ind == IND_LAST) state_next = S_STOP;
               else ind_next = ind + 1'b1;
            end else count_next = count + 1'b1;
         S_STOP:
            if (count == BIT_LAST) begin
               count_next = '0;
               valid_next = rx_s == STOP_BIT;
               err_next = rx_s != STOP_BIT;
               val_next = (rx_s == STOP_BIT) ? shift : val_out;
               state_next = (rx_s == STOP_BIT) ? S_IDLE : S_RECOVER;
            end else count_next = count + 1'b1;
         S_RECOVER:
            if (rx_s) state_next = S_IDLE;
         default: begin
            state_next = S_IDLE;
            count_next = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: scoreboard bench for serial_rx with DIVISOR=15
module tb_serial_rx;
   localparam int DIV = 15;
   localparam int BIT = DIV + 1;
   localparam int HALF = BIT / 2;
   localparam int LAT = 2 + HALF + 9 * BIT + 1;
   typedef struct {
      logic [1:0] kind;
      logic [7:0] data;
      int at;
   } ev_t;
   logic clk_in = 1'b0, rst_in = 1'b1, data_in = 1'b0;
   logic [7:0] val_out;
   logic valid_out, frame_err_out, busy_out;
   int checks = 0, errors = 0, cyc_n = 0;
   ev_t exp_q[$], obs_q[$];
   serial_rx #(.DIVISOR(DIV), .DATA_WIDTH(8)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .data_in      (data_in),
      .val_out      (val_out),
      .valid_out    (valid_out),
      .frame_err_out(frame_err_out),
      .busy_out     (busy_out)
   );
   always #5 clk_in = ~clk_in;
   // Advance n cycles, recording every strobe the DUT raises (kind = {valid, err}).
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         cyc_n++;
         #1;
         if (valid_out || frame_err_out)
            obs_q.push_back('{kind: {valid_out, frame_err_out}, data: val_out, at: cyc_n});
      end
   endtask
   // Drive one frame and push the outcome it must produce; prior is the byte val_out must hold on error.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic [7:0] prior);
      logic [9:0] line;
      line = {stop, b, 1'b0};
      exp_q.push_back('{kind: stop ? 2'b10 : 2'b01, data: stop ? b : prior, at: cyc_n + LAT});
      for (int i = 0; i < 10; i++) begin
         data_in = line[i];
         cyc(BIT);
      end
   endtask
   task automatic test_reset;
      rst_in = 1'b1;
      data_in = 1'b0;
      cyc(4);
      checks++;
      if ({val_out, valid_out, frame_err_out, busy_out} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h/%b/%b/%b want 00/0/0/0", val_out, valid_out, frame_err_out, busy_out);
      end
      rst_in = 1'b0;
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         checks++;
         if (busy_out !== 1'b0) begin
            errors++;
            $display("FAIL held_low_busy cycle %0d got %b want 0", i, busy_out);
         end
      end
      checks++;
      if (obs_q.size() != 0 || val_out !== 8'h00) begin
         errors++;
         $display("FAIL held_low_quiet got %0d strobes val %h want 0 strobes val 00", obs_q.size(), val_out);
      end
      obs_q.delete();
      data_in = 1'b1;
      cyc(10);
   endtask
   task automatic test_frame;
      ev_t e, o;
      send_frame(8'hA5, 1'b1, 8'h00);
      data_in = 1'b1;
      cyc(20);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL frame_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.kind !== e.kind || o.data !== e.data || o.at !== e.at) begin
            errors++;
            $display("FAIL frame got kind %b data %h at %0d want kind %b data %h at %0d", o.kind, o.data, o.at, e.kind, e.data, e.at);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask
   task automatic test_glitch;
      int c0;
      c0 = cyc_n;
      data_in = 1'b0;
      cyc(4);
      data_in = 1'b1;
      cyc(c0 + 3 - cyc_n);
      checks++;
      if (busy_out !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy_rise got %b want 1", busy_out);
      end
      cyc(c0 + 10 - cyc_n);
      checks++;
      if (busy_out !== 1'b1) begin
         errors++;
         $display("FAIL glitch_busy_hold got %b want 1", busy_out);
      end
      cyc(1);
      checks++;
      if (busy_out !== 1'b0) begin
         errors++;
         $display("FAIL glitch_busy_fall got %b want 0", busy_out);
      end
      cyc(40);
      checks++;
      if (obs_q.size() != 0 || val_out !== 8'hA5 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL glitch_quiet got %0d strobes val %h busy %b want 0 strobes val a5 busy 0", obs_q.size(), val_out, busy_out);
      end
      obs_q.delete();
   endtask
   task automatic test_frame_err;
      ev_t e, o;
      send_frame(8'h3C, 1'b0, 8'hA5);
      data_in = 1'b1;
      cyc(30);
      checks++;
      if (val_out !== 8'hA5 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL err_hold got val %h busy %b want val a5 busy 0", val_out, busy_out);
      end
      send_frame(8'h81, 1'b1, 8'hA5);
      data_in = 1'b1;
      cyc(20);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.kind !== e.kind || o.data !== e.data || o.at !== e.at) begin
            errors++;
            $display("FAIL err_frame got kind %b data %h at %0d want kind %b data %h at %0d", o.kind, o.data, o.at, e.kind, e.data, e.at);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask
   task automatic test_back_to_back;
      ev_t e, o;
      int prev_at;
      send_frame(8'h00, 1'b1, 8'h81);
      send_frame(8'hFF, 1'b1, 8'h00);
      send_frame(8'h55, 1'b1, 8'hFF);
      data_in = 1'b1;
      cyc(20);
      checks++;
      if (obs_q.size() != 3) begin
         errors++;
         $display("FAIL b2b_count got %0d want 3", obs_q.size());
      end
      prev_at = -1;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.kind !== e.kind || o.data !== e.data || o.at !== e.at || (prev_at >= 0 && o.at - prev_at != 10 * BIT)) begin
            errors++;
            $display("FAIL b2b got kind %b data %h at %0d want kind %b data %h at %0d", o.kind, o.data, o.at, e.kind, e.data, e.at);
         end
         prev_at = o.at;
      end
      exp_q.delete();
      obs_q.delete();
   endtask
   task automatic test_reset_mid;
      ev_t e, o;
      logic [9:0] line;
      line = {1'b1, 8'h7E, 1'b0};
      for (int i = 0; i < 4; i++) begin
         data_in = line[i];
         cyc(BIT);
      end
      checks++;
      if (busy_out !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got %b want 1", busy_out);
      end
      rst_in = 1'b1;
      cyc(3);
      data_in = 1'b1;
      cyc(2);
      checks++;
      if ({val_out, valid_out, frame_err_out, busy_out} !== 11'd0) begin
         errors++;
         $display("FAIL mid_reset got %h/%b/%b/%b want 00/0/0/0", val_out, valid_out, frame_err_out, busy_out);
      end
      rst_in = 1'b0;
      cyc(BIT * 8);
      send_frame(8'h42, 1'b1, 8'h00);
      data_in = 1'b1;
      cyc(20);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL mid_count got %0d want 1", obs_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.kind !== e.kind || o.data !== e.data || o.at !== e.at) begin
            errors++;
            $display("FAIL mid_frame got kind %b data %h at %0d want kind %b data %h at %0d", o.kind, o.data, o.at, e.kind, e.data, e.at);
         end
      end
      exp_q.delete();
      obs_q.delete();
   endtask
   initial begin
      test_reset();
      test_frame();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
